// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DIV   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int unsigned DIV_CYCLES_DEF = 33;
  localparam int unsigned REG_W          = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare: EX load whose destination is a source read by ID.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wreg,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit   = id_rs_used && (id_rs == ex_wreg);
    rt_hit   = id_rt_used && (id_rt == ex_wreg);
    // $0 is hardwired, so a load targeting it never creates a dependency
    load_use = ex_memread && (ex_wreg != '0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             ex_div_start,
  input  logic             if_mem_wait,
  input  logic             mem_mem_wait,
  input  logic             mem_exc,
  input  logic             mem_eret,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic             if_id_stall,
  output logic             if_id_refresh,
  output logic             id_ex_stall,
  output logic             id_ex_refresh,
  output logic             ex_mem_stall,
  output logic             ex_mem_refresh,
  output logic             mem_wb_stall,
  output logic             mem_wb_refresh,
  output logic             div_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_flush_cnt
`endif
);

  // The start cycle already stalls and the counter==0 cycle is the completion
  // cycle, so the register only needs to cover the DIV_CYCLES-2 in between.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             load_use;
  logic             flush;
  logic             div_hold;

  logic s_pc, s_if, s_ide, s_exm;
  logic r_if, r_ide, r_exm, r_mw;
  logic redir;

  hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .ex_memread (ex_memread),
    .ex_wreg    (ex_wreg),
    .load_use   (load_use)
  );

  always_comb begin
    flush    = mem_exc || mem_eret;
    div_hold = ((state == ST_RUN) && ex_div_start) ||
               ((state == ST_DIV) && (cnt != '0));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_RUN;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush) begin
            state <= ST_FLUSH;
          end else if (!mem_mem_wait && ex_div_start) begin
            state  <= ST_DIV;
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state  <= ST_FLUSH;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (!mem_mem_wait) begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          state <= flush ? ST_FLUSH : ST_RUN;
        end
        default: begin
          state  <= ST_RUN;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    s_pc  = 1'b0;
    s_if  = 1'b0;
    s_ide = 1'b0;
    s_exm = 1'b0;
    r_if  = 1'b0;
    r_ide = 1'b0;
    r_exm = 1'b0;
    r_mw  = 1'b0;
    redir = 1'b0;

    if (flush) begin
      redir = 1'b1;
      r_if  = 1'b1;
      r_ide = 1'b1;
      r_exm = 1'b1;
    end else if (mem_mem_wait) begin
      s_pc  = 1'b1;
      s_if  = 1'b1;
      s_ide = 1'b1;
      s_exm = 1'b1;
      r_mw  = 1'b1;
    end else if (div_hold) begin
      s_pc  = 1'b1;
      s_if  = 1'b1;
      s_ide = 1'b1;
      r_exm = 1'b1;
    end else if (if_mem_wait || load_use) begin
      s_pc  = 1'b1;
      s_if  = 1'b1;
      r_ide = 1'b1;
    end

    // Redirected fetch is not valid yet, so IF/ID gets a second bubble
    if (state == ST_FLUSH) begin
      r_if = 1'b1;
    end

    if (!resetn) begin
      s_pc  = 1'b0;
      s_if  = 1'b0;
      s_ide = 1'b0;
      s_exm = 1'b0;
      r_if  = 1'b1;
      r_ide = 1'b1;
      r_exm = 1'b1;
      r_mw  = 1'b1;
      redir = 1'b0;
    end

    pc_stall       = s_pc;
    pc_redirect    = redir;
    if_id_stall    = s_if && !r_if;
    if_id_refresh  = r_if;
    id_ex_stall    = s_ide && !r_ide;
    id_ex_refresh  = r_ide;
    ex_mem_stall   = s_exm && !r_exm;
    ex_mem_refresh = r_exm;
    mem_wb_stall   = 1'b0;
    mem_wb_refresh = r_mw;
    div_busy       = busy_q && resetn;
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (pc_stall) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (pc_redirect) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected control vectors.
module tb_pipe_hazard_ctrl;

  // Vector order: pc_stall pc_redirect if_id_stall if_id_refresh id_ex_stall
  // id_ex_refresh ex_mem_stall ex_mem_refresh mem_wb_stall mem_wb_refresh div_busy
  localparam logic [10:0] O_NONE  = 11'b00000000000;
  localparam logic [10:0] O_BUSY  = 11'b00000000001;
  localparam logic [10:0] O_RESET = 11'b00010101010;
  localparam logic [10:0] O_LU    = 11'b10100100000;
  localparam logic [10:0] O_DIV   = 11'b10101001000;
  localparam logic [10:0] O_DWAIT = 11'b10101010010;
  localparam logic [10:0] O_FLUSH = 11'b01010101000;
  localparam logic [10:0] O_FLST  = 11'b00010000000;
  localparam logic [10:0] O_FLIFW = 11'b10010100000;
  localparam logic [10:0] O_FLDW  = 11'b10011010010;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic       id_rs_used, id_rt_used, ex_memread, ex_div_start;
  logic       if_mem_wait, mem_mem_wait, mem_exc, mem_eret;
  logic       pc_stall, pc_redirect, if_id_stall, if_id_refresh;
  logic       id_ex_stall, id_ex_refresh, ex_mem_stall, ex_mem_refresh;
  logic       mem_wb_stall, mem_wb_refresh, div_busy;
  logic [10:0] outs;
  logic [10:0] exp_q[$];
  logic [10:0] e;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .ex_memread     (ex_memread),
    .ex_wreg        (ex_wreg),
    .ex_div_start   (ex_div_start),
    .if_mem_wait    (if_mem_wait),
    .mem_mem_wait   (mem_mem_wait),
    .mem_exc        (mem_exc),
    .mem_eret       (mem_eret),
    .pc_stall       (pc_stall),
    .pc_redirect    (pc_redirect),
    .if_id_stall    (if_id_stall),
    .if_id_refresh  (if_id_refresh),
    .id_ex_stall    (id_ex_stall),
    .id_ex_refresh  (id_ex_refresh),
    .ex_mem_stall   (ex_mem_stall),
    .ex_mem_refresh (ex_mem_refresh),
    .mem_wb_stall   (mem_wb_stall),
    .mem_wb_refresh (mem_wb_refresh),
    .div_busy       (div_busy)
  );

  assign outs = {pc_stall, pc_redirect, if_id_stall, if_id_refresh, id_ex_stall,
                 id_ex_refresh, ex_mem_stall, ex_mem_refresh, mem_wb_stall,
                 mem_wb_refresh, div_busy};

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    ex_memread = 1'b0; ex_wreg = 5'd0; ex_div_start = 1'b0;
    if_mem_wait = 1'b0; mem_mem_wait = 1'b0; mem_exc = 1'b0; mem_eret = 1'b0;
  endtask

  task automatic lu(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                    input logic rtu, input logic mrd, input logic [4:0] wreg);
    id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    ex_memread = mrd; ex_wreg = wreg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 1) lu(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5);
      if (k == 2) begin idle(); resetn = 1'b1; end
      exp_q.push_back(k < 2 ? O_RESET : O_NONE);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %b expected %b", k, outs, e);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [10:0] x;
    for (int k = 0; k < 8; k++) begin
      idle();
      x = O_NONE;
      case (k)
        0: begin lu(5'd5, 5'd9, 1'b1, 1'b0, 1'b1, 5'd5); x = O_LU; end
        1: lu(5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 5'd5);
        2: begin lu(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7); x = O_LU; end
        3: lu(5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7);
        4: lu(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0);
        5: lu(5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5);
        6: begin if_mem_wait = 1'b1; x = O_LU; end
        default: x = O_NONE;
      endcase
      exp_q.push_back(x);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b expected %b", k, outs, e);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [10:0] x;
    for (int k = 0; k < 7; k++) begin
      idle();
      x = O_NONE;
      case (k)
        0: begin mem_mem_wait = 1'b1; ex_div_start = 1'b1; x = O_DWAIT; end
        1: begin
          mem_mem_wait = 1'b1; if_mem_wait = 1'b1;
          lu(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8); x = O_DWAIT;
        end
        2: begin
          mem_exc = 1'b1; mem_mem_wait = 1'b1; ex_div_start = 1'b1;
          lu(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8); x = O_FLUSH;
        end
        3: x = O_FLST;
        4: begin mem_eret = 1'b1; x = O_FLUSH; end
        5: begin if_mem_wait = 1'b1; x = O_FLIFW; end
        default: x = O_NONE;
      endcase
      exp_q.push_back(x);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL priority[%0d]: got %b expected %b", k, outs, e);
      end
      tick();
    end
  endtask

  task automatic test_div();
    logic [10:0] x;
    for (int k = 1; k <= 34; k++) begin
      idle();
      ex_div_start = (k <= 33);
      if (k == 5) lu(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2);
      if (k == 1) x = O_DIV;
      else if (k <= 32) x = O_DIV | O_BUSY;
      else if (k == 33) x = O_BUSY;
      else x = O_NONE;
      exp_q.push_back(x);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL div[%0d]: got %b expected %b", k, outs, e);
      end
      tick();
    end
  endtask

  task automatic test_div_mem_wait();
    logic [10:0] x;
    for (int k = 1; k <= 38; k++) begin
      idle();
      ex_div_start = (k <= 37);
      mem_mem_wait = (k >= 23 && k <= 26);
      if (k == 1) x = O_DIV;
      else if (k <= 22) x = O_DIV | O_BUSY;
      else if (k <= 26) x = O_DWAIT | O_BUSY;
      else if (k <= 36) x = O_DIV | O_BUSY;
      else if (k == 37) x = O_BUSY;
      else x = O_NONE;
      exp_q.push_back(x);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL div_mem_wait[%0d]: got %b expected %b", k, outs, e);
      end
      tick();
    end
  endtask

  task automatic test_div_exc();
    logic [10:0] x;
    for (int k = 1; k <= 15; k++) begin
      idle();
      ex_div_start = (k <= 13);
      mem_exc = (k == 13);
      if (k == 1) x = O_DIV;
      else if (k <= 12) x = O_DIV | O_BUSY;
      else if (k == 13) x = O_FLUSH | O_BUSY;
      else if (k == 14) x = O_FLST;
      else x = O_NONE;
      exp_q.push_back(x);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL div_exc[%0d]: got %b expected %b", k, outs, e);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_div();
    logic [10:0] x;
    for (int k = 1; k <= 7; k++) begin
      idle();
      ex_div_start = (k <= 5);
      resetn = !(k == 5 || k == 6);
      if (k == 1) x = O_DIV;
      else if (k <= 4) x = O_DIV | O_BUSY;
      else if (k <= 6) x = O_RESET;
      else x = O_NONE;
      exp_q.push_back(x);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL reset_mid_div[%0d]: got %b expected %b", k, outs, e);
      end
      tick();
    end
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [10:0] x;
    for (int k = 0; k < 5; k++) begin
      idle();
      x = O_NONE;
      case (k)
        0: begin lu(5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11); x = O_LU; end
        1: begin mem_exc = 1'b1; x = O_FLUSH; end
        2: begin mem_mem_wait = 1'b1; x = O_FLDW; end
        3: begin lu(5'd0, 5'd12, 1'b0, 1'b1, 1'b1, 5'd12); x = O_LU; end
        default: x = O_NONE;
      endcase
      exp_q.push_back(x);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", k, outs, e);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle();
    resetn = 1'b0;
    test_reset();
    test_load_use();
    test_priority();
    test_div();
    test_div_mem_wait();
    test_div_exc();
    test_reset_mid_div();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
